// File: rtl/astro_loader_pkg.sv
// Shared state encoding, image indices and power-of-two sizing helper for the Astrocade loader.
// No timing or handshake of its own.
package astro_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

  localparam logic [7:0] CART_INDEX_DEF = 8'd1;
  localparam logic [7:0] BIOS_INDEX_DEF = 8'd0;
  localparam int         SIZE_W         = 14;
  localparam int         CART_MAX       = 8192;

  // Smallest power of two >= x (x=0 gives 1), clamped to the 8 KB window.
  function automatic logic [SIZE_W-1:0] ceil_pow2(input logic [SIZE_W-1:0] x);
    logic [SIZE_W:0] r;
    r = (SIZE_W+1)'(1);
    for (int i = 0; i < SIZE_W; i++) begin
      if (r < {1'b0, x}) r = r << 1;
    end
    if (r > (SIZE_W+1)'(CART_MAX)) r = (SIZE_W+1)'(CART_MAX);
    return r[SIZE_W-1:0];
  endfunction

endpackage

// File: rtl/astro_pow2_mask.sv
// Rounds a cart length up to its mirror size P (>= MIN_CART_BYTES, <= 8 KB) and mask P-1.
// Purely combinational, zero latency, no backpressure.
module astro_pow2_mask
  import astro_loader_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int MIN_CART_BYTES = 2048
) (
  input  logic [SIZE_W-1:0] i_size,
  output logic [SIZE_W-1:0] o_pow2,
  output logic [ADDR_W-1:0] o_mask
);

  logic [SIZE_W-1:0] pow2;

  always_comb begin
    pow2 = ceil_pow2(i_size);
    if (pow2 < SIZE_W'(MIN_CART_BYTES)) pow2 = SIZE_W'(MIN_CART_BYTES);
    o_pow2 = pow2;
    o_mask = ADDR_W'(pow2 - SIZE_W'(1));
  end

endmodule

// File: rtl/astro_cart_loader.sv
// ioctl -> cart/BIOS dpram loader with power-of-two padding and mirror mask; write latency 1 cycle,
// stalls hps_io via O_IOCTL_WAIT only during FILL. Optional checksum: ASTRO_CART_CKSUM_EN.
module astro_cart_loader
  import astro_loader_pkg::*;
#(
  parameter int         ADDR_W         = 13,
  parameter int         MIN_CART_BYTES = 2048,
  parameter logic [7:0] FILL_BYTE      = 8'hFF,
  parameter logic [7:0] CART_INDEX     = CART_INDEX_DEF,
  parameter logic [7:0] BIOS_INDEX     = BIOS_INDEX_DEF
) (
  input  logic              CLK,
  input  logic              I_RESET_L,
  input  logic              I_IOCTL_DOWNLOAD,
  input  logic              I_IOCTL_WR,
  input  logic [24:0]       I_IOCTL_ADDR,
  input  logic [7:0]        I_IOCTL_DOUT,
  input  logic [7:0]        I_IOCTL_INDEX,
  output logic              O_IOCTL_WAIT,
  output logic [ADDR_W-1:0] O_RAM_ADDR,
  output logic [7:0]        O_RAM_DATA,
  output logic              O_CART_WE,
  output logic              O_BIOS_WE,
  output logic              O_BUSY,
  output logic [13:0]       O_CART_SIZE,
  output logic              O_OVERSIZE,
`ifdef ASTRO_CART_CKSUM_EN
  output logic [15:0]       O_CKSUM,
  output logic              O_CKSUM_VALID,
`endif
  input  logic [ADDR_W-1:0] I_CAS_ADDR,
  output logic [ADDR_W-1:0] O_CAS_ADDR
);

  state_t              state_q, state_d;
  logic [7:0]          index_q, index_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_data_q, ram_data_d;
  logic                cart_we_q, cart_we_d;
  logic                bios_we_q, bios_we_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                oversize_q, oversize_d;
  logic [ADDR_W-1:0]   mask_q, mask_d;

  logic [SIZE_W-1:0]   pow2;
  logic [ADDR_W-1:0]   pow2_mask;
  logic                wr_take;
  logic                wr_in_range;
  logic [7:0]          cur_index;
  logic [SIZE_W-1:0]   cur_size;
  logic [SIZE_W-1:0]   wr_end;

`ifdef ASTRO_CART_CKSUM_EN
  logic [15:0]         cksum_q, cksum_d, cur_cksum;
  logic                cksum_vld_q, cksum_vld_d;
`endif

  astro_pow2_mask #(
    .ADDR_W         (ADDR_W),
    .MIN_CART_BYTES (MIN_CART_BYTES)
  ) u_pow2_mask (
    .i_size (size_q),
    .o_pow2 (pow2),
    .o_mask (pow2_mask)
  );

  assign wr_in_range = (I_IOCTL_ADDR < 25'(CART_MAX));
  assign wr_end      = SIZE_W'(I_IOCTL_ADDR[ADDR_W-1:0]) + SIZE_W'(1);

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    cart_we_d  = 1'b0;
    bios_we_d  = 1'b0;
    size_d     = size_q;
    fill_cnt_d = fill_cnt_q;
    oversize_d = oversize_q;
    mask_d     = mask_q;
    wr_take    = 1'b0;
    cur_index  = index_q;
    cur_size   = size_q;
`ifdef ASTRO_CART_CKSUM_EN
    cksum_d     = cksum_q;
    cksum_vld_d = cksum_vld_q;
    cur_cksum   = cksum_q;
`endif

    case (state_q)
      IDLE: begin
        // A byte arriving in the same cycle as the DOWNLOAD rise is taken against the new index.
        if (I_IOCTL_DOWNLOAD) begin
          index_d   = I_IOCTL_INDEX;
          cur_index = I_IOCTL_INDEX;
          wr_take   = I_IOCTL_WR;
          state_d   = LOAD;
          if (I_IOCTL_INDEX == CART_INDEX) begin
            size_d     = '0;
            cur_size   = '0;
            oversize_d = 1'b0;
            mask_d     = '1;
`ifdef ASTRO_CART_CKSUM_EN
            cksum_d     = '0;
            cur_cksum   = '0;
            cksum_vld_d = 1'b0;
`endif
          end
        end
      end
      LOAD: begin
        if (I_IOCTL_DOWNLOAD) begin
          wr_take = I_IOCTL_WR;
        end else begin
          state_d = IDLE;
          if (index_q == CART_INDEX) begin
            if (size_q == '0) begin
              mask_d = '1;
            end else if (size_q < pow2) begin
              state_d    = FILL;
              fill_cnt_d = size_q;
            end else begin
              mask_d = pow2_mask;
            end
`ifdef ASTRO_CART_CKSUM_EN
            cksum_vld_d = (state_d == IDLE);
`endif
          end
        end
      end
      FILL: begin
        ram_addr_d = fill_cnt_q[ADDR_W-1:0];
        ram_data_d = FILL_BYTE;
        cart_we_d  = 1'b1;
        fill_cnt_d = fill_cnt_q + SIZE_W'(1);
        if (fill_cnt_q == pow2 - SIZE_W'(1)) begin
          mask_d  = pow2_mask;
          state_d = IDLE;
`ifdef ASTRO_CART_CKSUM_EN
          cksum_vld_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_take) begin
      if (wr_in_range) begin
        ram_addr_d = I_IOCTL_ADDR[ADDR_W-1:0];
        ram_data_d = I_IOCTL_DOUT;
        if (cur_index == CART_INDEX) begin
          cart_we_d = 1'b1;
          if (wr_end > cur_size) size_d = wr_end;
`ifdef ASTRO_CART_CKSUM_EN
          cksum_d = cur_cksum + {8'h00, I_IOCTL_DOUT};
`endif
        end else if (cur_index == BIOS_INDEX) begin
          bios_we_d = 1'b1;
        end
      end else if (cur_index == CART_INDEX) begin
        oversize_d = 1'b1;
        size_d     = SIZE_W'(CART_MAX);
      end
    end
  end

  always_ff @(posedge CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q    <= IDLE;
      index_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      cart_we_q  <= 1'b0;
      bios_we_q  <= 1'b0;
      size_q     <= '0;
      fill_cnt_q <= '0;
      oversize_q <= 1'b0;
      mask_q     <= '1;
`ifdef ASTRO_CART_CKSUM_EN
      cksum_q     <= '0;
      cksum_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      cart_we_q  <= cart_we_d;
      bios_we_q  <= bios_we_d;
      size_q     <= size_d;
      fill_cnt_q <= fill_cnt_d;
      oversize_q <= oversize_d;
      mask_q     <= mask_d;
`ifdef ASTRO_CART_CKSUM_EN
      cksum_q     <= cksum_d;
      cksum_vld_q <= cksum_vld_d;
`endif
    end
  end

  // BUSY also covers the trailing registered write so reset is held until the last byte lands.
  assign O_BUSY       = (state_q != IDLE) | cart_we_q | bios_we_q;
  assign O_IOCTL_WAIT = (state_q == FILL) & I_IOCTL_DOWNLOAD;
  assign O_RAM_ADDR   = ram_addr_q;
  assign O_RAM_DATA   = ram_data_q;
  assign O_CART_WE    = cart_we_q;
  assign O_BIOS_WE    = bios_we_q;
  assign O_CART_SIZE  = size_q;
  assign O_OVERSIZE   = oversize_q;
  assign O_CAS_ADDR   = I_CAS_ADDR & mask_q;
`ifdef ASTRO_CART_CKSUM_EN
  assign O_CKSUM       = cksum_q;
  assign O_CKSUM_VALID = cksum_vld_q & (state_q == IDLE);
`endif

endmodule
